// File: rtl/bcd_convert_ctrl_pkg.sv
// Shared constants for the sequential binary-to-BCD converter:
// FSM state encodings and the shift-and-add-3 digit adjust constants.
package bcd_convert_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam logic [3:0]  BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0]  BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_convert_ctrl_if.sv
// Request/result bundle of the BCD converter. The requester drives start/bin,
// the converter drives busy/done and the registered bcd/blank result.
interface bcd_convert_ctrl_if #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 5
);
  import bcd_convert_ctrl_pkg::*;

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  modport master (output start, output bin, input busy, input done, input bcd, input blank);
  modport slave  (input start, input bin, output busy, output done, output bcd, output blank);

endinterface

// File: rtl/bcd_convert_ctrl_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the
// next shift so that it carries correctly into the next decade. 4-bit wrap.
module bcd_convert_ctrl_digit_adj
  import bcd_convert_ctrl_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Combinational add-3 correction
  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional feature macro: BCD_BLANK_EN (leading-zero blank mask on bus.blank).
module bcd_convert_ctrl
  import bcd_convert_ctrl_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  bcd_convert_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int unsigned SCR_W = 4 * DIGITS;

  logic [1:0]             r_state;
  logic [BIN_W-1:0]       r_shift;
  logic [SCR_W-1:0]       r_scratch;
  logic [CNT_W-1:0]       r_cnt;
  logic [SCR_W-1:0]       r_bcd;

  logic [SCR_W-1:0]       w_adj;
  logic [SCR_W+BIN_W-1:0] w_cat;
  logic [SCR_W-1:0]       w_scratch_nxt;
  logic [BIN_W-1:0]       w_shift_nxt;
  logic                   w_accept;
  logic                   w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_convert_ctrl_digit_adj u_adj (
      .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjusted scratch and the binary operand shift left together as one register
  assign w_cat         = {w_adj, r_shift} << 1;
  assign w_scratch_nxt = w_cat[SCR_W+BIN_W-1:BIN_W];
  assign w_shift_nxt   = w_cat[BIN_W-1:0];

  // DONE accepts a new request exactly like IDLE, allowing back-to-back conversions
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_cnt == CNT_W'(BIN_W - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: r_state <= bus.start ? ST_SHIFT : ST_IDLE;
        ST_SHIFT:         if (w_last) r_state <= ST_DONE;
        default:          r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand shift, scratch digits and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_shift   <= bus.bin;
      r_scratch <= '0;
      r_cnt     <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_shift   <= w_shift_nxt;
      r_scratch <= w_scratch_nxt;
      r_cnt     <= r_cnt + CNT_W'(1);
    end
  end

  // Result register: loaded with the final shift on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd <= '0;
    end else if ((r_state == ST_SHIFT) && w_last) begin
      r_bcd <= w_scratch_nxt;
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] w_blank_nxt;
  logic [DIGITS-1:0] r_blank;

  // Digit k blanks when it and every higher digit are zero; digit 0 never blanks
  always_comb begin
    logic w_zero_above;
    w_blank_nxt  = '0;
    w_zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_zero_above   = w_zero_above && (w_scratch_nxt[k*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      w_blank_nxt[k] = w_zero_above;
    end
  end

  // Blank mask registered alongside the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank <= '0;
    end else if ((r_state == ST_SHIFT) && w_last) begin
      r_blank <= w_blank_nxt;
    end
  end

  assign bus.blank = r_blank;
`else
  assign bus.blank = '0;
`endif

  assign bus.busy = (r_state == ST_SHIFT);
  assign bus.done = (r_state == ST_DONE);
  assign bus.bcd  = r_bcd;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Self-checking bench for bcd_convert_ctrl (BIN_W=14, DIGITS=5) with a result scoreboard.
module tb_bcd_convert_ctrl;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_convert_ctrl_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bcd_convert_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_push   = 0;

  logic [4*DIGITS-1:0] q_bcd[$];
  logic [DIGITS-1:0]   q_blank[$];
  logic [4*DIGITS-1:0] last_bcd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] model_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] model_blank(input int v);
    logic [DIGITS-1:0] r;
    r = '0;
`ifdef BCD_BLANK_EN
    for (int k = 1; k < DIGITS; k++) begin
      if (v < 10 ** k) r[k] = 1'b1;
    end
`else
    r = '0 & DIGITS'(v);
`endif
    return r;
  endfunction

  task automatic push_exp(input int v);
    q_bcd.push_back(model_bcd(v));
    q_blank.push_back(model_blank(v));
    n_push++;
  endtask

  // One-cycle start; returns at the negedge after the acceptance edge
  task automatic start_conv(input int v, input bit expect_result);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = BIN_W'(v);
    if (expect_result) push_exp(v);
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = BIN_W'($urandom);
  endtask

  // Counts negedges until done is seen, bounded
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.done) return;
    end
    check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  // Scoreboard monitor, sampling just after each rising edge
  initial begin
    logic [4*DIGITS-1:0] eb;
    logic [DIGITS-1:0]   ebl;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_bcd = '0;
      end else begin
        check("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
        if (bus.done) begin
          n_done++;
          if (q_bcd.size() == 0) begin
            check("stray_done", 32'(bus.done), 32'd0);
          end else begin
            eb  = q_bcd.pop_front();
            ebl = q_blank.pop_front();
            check("bcd", 32'(bus.bcd), 32'(eb));
            check("blank", 32'(bus.blank), 32'(ebl));
          end
          last_bcd = bus.bcd;
        end else begin
          check("bcd_hold", 32'(bus.bcd), 32'(last_bcd));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int t1;
    bus.start = 1'b0;
    bus.bin   = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'd0);
    check("rst_blank", 32'(bus.blank), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 9999 with latency measurement
    start_conv(9999, 1'b1);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    wait_done(c);
    check("latency", 32'(c), 32'd14);
    check("bcd_9999", 32'(bus.bcd), 32'h09999);

    // Extremes
    repeat (3) @(negedge clk);
    start_conv(0, 1'b1);
    wait_done(c);
    repeat (4) @(negedge clk);
    start_conv(16383, 1'b1);
    wait_done(c);
    check("bcd_max", 32'(bus.bcd), 32'h16383);

    // Back-to-back with start held through DONE
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = BIN_W'(42);
    push_exp(42);
    push_exp(123);
    @(negedge clk);
    bus.bin = BIN_W'(123);
    wait_done(c);
    t1 = cyc;
    check("b2b_first", 32'(bus.bcd), 32'h00042);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_restart_busy", 32'(bus.busy), 32'd1);
    wait_done(c);
    check("b2b_gap", 32'(cyc - t1), 32'd15);
    check("b2b_second", 32'(bus.bcd), 32'h00123);

    // Start during SHIFT is ignored
    repeat (3) @(negedge clk);
    start_conv(500, 1'b1);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = BIN_W'(777);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(c);
    check("ignored_start", 32'(bus.bcd), 32'h00500);
    repeat (20) @(negedge clk);

    // Reset in the middle of a conversion
    start_conv(1234, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_bcd", 32'(bus.bcd), 32'd0);
    check("abort_blank", 32'(bus.blank), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    start_conv(321, 1'b1);
    wait_done(c);

    // Blank mask boundaries
    start_conv(42, 1'b1);
    wait_done(c);
    start_conv(0, 1'b1);
    wait_done(c);
    start_conv(10000, 1'b1);
    wait_done(c);
    start_conv(9, 1'b1);
    wait_done(c);

    // A few random operands
    for (int i = 0; i < 6; i++) begin
      start_conv(int'($urandom_range(0, 16383)), 1'b1);
      wait_done(c);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(q_bcd.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_push));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
